rom_fetch_bridge: RTL and testbench

//   Sits directly downstream of the SNES top-level mapper mux. It consumes rom_addr/rom_ce_n/rom_oe_n/rom_word
//   and returns rom_q. Each ROM read becomes a single-word req/ack transaction to the SDRAM controller.
//   The last fetched word is held in a tagged buffer, so repeated reads of the same word are served without SDRAM traffic.

---
 rtl/rom_fetch_bridge_if.sv | 26 ++
 rtl/rom_fetch_bridge.sv | 160 ++++++++++++++++
 tb/tb_rom_fetch_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_bridge_if.sv
// ROM-side and SDRAM-side signals of rom_fetch_bridge.
// The bridge uses the slave modport; the mapper/SDRAM environment uses master.
interface rom_fetch_bridge_if #(
   parameter int unsigned ADDR_W = 24
);
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_ce_n;
   logic              rom_oe_n;
   logic              rom_word;
   logic [15:0]       rom_q;
   logic              rom_busy;
   logic              sd_req;
   logic [ADDR_W-2:0] sd_addr;
   logic              sd_ack;
   logic [15:0]       sd_q;

   modport slave (
      input  rom_addr, rom_ce_n, rom_oe_n, rom_word, sd_ack, sd_q,
      output rom_q, rom_busy, sd_req, sd_addr
   );

   modport master (
      output rom_addr, rom_ce_n, rom_oe_n, rom_word, sd_ack, sd_q,
      input  rom_q, rom_busy, sd_req, sd_addr
   );
endinterface

// File: rtl/rom_fetch_bridge.sv
// ROM read bridge: one-word tagged buffer in front of a req/ack SDRAM read port.
// Define ROM_PREFETCH_EN to add a next-word prefetch buffer and the StPfReq state.
module rom_fetch_bridge #(
   parameter int unsigned ADDR_W = 24
) (
   input logic              mclk,
   input logic              reset,
   rom_fetch_bridge_if.slave bus
);
   localparam int unsigned WordW = ADDR_W - 1;

`ifdef ROM_PREFETCH_EN
   typedef enum logic [1:0] {StIdle, StReq, StPfReq} state_e;
`else
   typedef enum logic [1:0] {StIdle, StReq} state_e;
`endif

   state_e             state_q, state_d;
   logic               buf_valid_q, buf_valid_d;
   logic [WordW-1:0]   buf_tag_q, buf_tag_d;
   logic [15:0]        buf_data_q, buf_data_d;
   logic [WordW-1:0]   sd_addr_q, sd_addr_d;
   logic [15:0]        hold_q;

   logic               active;
   logic [WordW-1:0]   word_addr;
   logic               buf_hit, pf_hit, hit;
   logic [15:0]        src_data, rom_q_now;

   assign active    = ~bus.rom_ce_n & ~bus.rom_oe_n;
   assign word_addr = bus.rom_addr[ADDR_W-1:1];
   assign buf_hit   = buf_valid_q & (buf_tag_q == word_addr);

`ifdef ROM_PREFETCH_EN
   logic               pf_valid_q, pf_valid_d;
   logic [WordW-1:0]   pf_tag_q, pf_tag_d;
   logic [15:0]        pf_data_q, pf_data_d;
   // Set after any demand fill; the next prefetch target is always buf_tag_q + 1.
   logic               pf_pend_q, pf_pend_d;

   assign pf_hit   = pf_valid_q & (pf_tag_q == word_addr);
   assign src_data = (pf_hit & ~buf_hit) ? pf_data_q : buf_data_q;
`else
   assign pf_hit   = 1'b0;
   assign src_data = buf_data_q;
`endif

   assign hit = buf_hit | pf_hit;

   always_comb begin
      if (bus.rom_word) begin
         rom_q_now = src_data;
      end else begin
         rom_q_now = {8'h00, bus.rom_addr[0] ? src_data[15:8] : src_data[7:0]};
      end
   end

   assign bus.rom_q    = active ? rom_q_now : hold_q;
   assign bus.rom_busy = active & (~hit | (state_q != StIdle));
   assign bus.sd_req   = (state_q != StIdle);
   assign bus.sd_addr  = sd_addr_q;

   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      sd_addr_d   = sd_addr_q;
`ifdef ROM_PREFETCH_EN
      pf_valid_d  = pf_valid_q;
      pf_tag_d    = pf_tag_q;
      pf_data_d   = pf_data_q;
      pf_pend_d   = pf_pend_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (active & ~hit) begin
               state_d   = StReq;
               sd_addr_d = word_addr;
`ifdef ROM_PREFETCH_EN
            end else if (active & pf_hit) begin
               buf_valid_d = 1'b1;
               buf_tag_d   = pf_tag_q;
               buf_data_d  = pf_data_q;
               pf_valid_d  = 1'b0;
               pf_pend_d   = 1'b1;
            end else if (pf_pend_q) begin
               // The pf buffer is about to be overwritten, so retire its old contents now.
               state_d    = StPfReq;
               sd_addr_d  = buf_tag_q + 1'b1;
               pf_valid_d = 1'b0;
               pf_pend_d  = 1'b0;
`endif
            end
         end
         StReq: begin
            if (bus.sd_ack) begin
               state_d     = StIdle;
               buf_valid_d = 1'b1;
               buf_tag_d   = sd_addr_q;
               buf_data_d  = bus.sd_q;
`ifdef ROM_PREFETCH_EN
               pf_pend_d   = 1'b1;
`endif
            end
         end
`ifdef ROM_PREFETCH_EN
         StPfReq: begin
            if (bus.sd_ack) begin
               state_d = StIdle;
               // Demand already waiting on this very word: treat the fill as a demand fill.
               if (active & (word_addr == sd_addr_q)) begin
                  buf_valid_d = 1'b1;
                  buf_tag_d   = sd_addr_q;
                  buf_data_d  = bus.sd_q;
                  pf_pend_d   = 1'b1;
               end else begin
                  pf_valid_d = 1'b1;
                  pf_tag_d   = sd_addr_q;
                  pf_data_d  = bus.sd_q;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
         sd_addr_q   <= '0;
         hold_q      <= '0;
`ifdef ROM_PREFETCH_EN
         pf_valid_q  <= 1'b0;
         pf_tag_q    <= '0;
         pf_data_q   <= '0;
         pf_pend_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
         sd_addr_q   <= sd_addr_d;
         if (active) begin
            hold_q <= rom_q_now;
         end
`ifdef ROM_PREFETCH_EN
         pf_valid_q  <= pf_valid_d;
         pf_tag_q    <= pf_tag_d;
         pf_data_q   <= pf_data_d;
         pf_pend_q   <= pf_pend_d;
`endif
      end
   end
endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Bench for rom_fetch_bridge: directed table, reset/abort corners, random reads vs a one-entry cache model.
// With ROM_PREFETCH_EN defined it runs a directed prefetch sequence instead.
module tb_rom_fetch_bridge;
   logic mclk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   rom_fetch_bridge_if #(.ADDR_W(24)) bus ();

   rom_fetch_bridge #(.ADDR_W(24)) dut (
      .mclk  (mclk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      logic [23:0] addr;
      logic        word;
      logic        miss;
      logic [15:0] fill;
      logic [15:0] exp_q;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mem(input logic [22:0] w);
      return w[15:0] ^ {w[22:16], 9'h000} ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] fmt(input logic [15:0] d, input logic a0, input logic w);
      if (w) return d;
      return {8'h00, a0 ? d[15:8] : d[7:0]};
   endfunction

   task automatic step();
      @(negedge mclk);
      #1;
   endtask

   task automatic go(input logic [23:0] a, input logic w);
      bus.rom_addr = a;
      bus.rom_word = w;
      bus.rom_ce_n = 1'b0;
      bus.rom_oe_n = 1'b0;
      #1;
   endtask

   task automatic ack(input logic [15:0] d);
      bus.sd_ack = 1'b1;
      bus.sd_q   = d;
      @(negedge mclk);
      bus.sd_ack = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      bus.rom_ce_n = 1'b1;
      bus.rom_oe_n = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   // One demand read; on a miss the bench plays SDRAM with the given latency and data.
   task automatic access(input string name, input logic [23:0] a, input logic w, input logic miss,
                         input logic [15:0] fill, input int lat, input logic [15:0] exp_q);
      go(a, w);
      if (miss) begin
         check({name, " busy on miss"}, 32'(bus.rom_busy), 1);
         step();
         check({name, " sd_req"}, 32'(bus.sd_req), 1);
         check({name, " sd_addr"}, 32'(bus.sd_addr), 32'(a[23:1]));
         for (int k = 0; k < lat; k++) begin
            step();
            check({name, " busy wait"}, 32'(bus.rom_busy), 1);
         end
         ack(fill);
      end
      check({name, " rom_q"}, 32'(bus.rom_q), 32'(exp_q));
      check({name, " busy done"}, 32'(bus.rom_busy), 0);
      step();
      if (!miss) step();
      check({name, " no sd_req"}, 32'(bus.sd_req), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [8];
      logic        mv;
      logic [22:0] mt, w;
      logic [15:0] md, last_q;
      logic [23:0] a;
      logic        wd, miss;

      tbl[0] = '{24'h008000, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF};
      tbl[1] = '{24'h008000, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
      tbl[2] = '{24'h008001, 1'b0, 1'b0, 16'h0000, 16'h00BE};
      tbl[3] = '{24'h008000, 1'b0, 1'b0, 16'h0000, 16'h00EF};
      tbl[4] = '{24'h00A001, 1'b1, 1'b1, 16'h1234, 16'h1234};
      tbl[5] = '{24'h00A001, 1'b0, 1'b0, 16'h0000, 16'h0012};
      tbl[6] = '{24'hFFFFFE, 1'b1, 1'b1, 16'hCAFE, 16'hCAFE};
      tbl[7] = '{24'hFFFFFF, 1'b0, 1'b0, 16'h0000, 16'h00CA};

      bus.rom_addr = '0;
      bus.rom_word = 1'b1;
      bus.rom_ce_n = 1'b1;
      bus.rom_oe_n = 1'b1;
      bus.sd_ack   = 1'b0;
      bus.sd_q     = '0;
      step();
      check("reset rom_q", 32'(bus.rom_q), 0);
      check("reset rom_busy", 32'(bus.rom_busy), 0);
      check("reset sd_req", 32'(bus.sd_req), 0);
      check("reset sd_addr", 32'(bus.sd_addr), 0);
      reset = 1'b0;
      step();

`ifdef ROM_PREFETCH_EN
      go(24'h008000, 1'b1);
      check("pf miss busy", 32'(bus.rom_busy), 1);
      step();
      check("pf demand sd_addr", 32'(bus.sd_addr), 32'h004000);
      ack(16'hBEEF);
      check("pf demand rom_q", 32'(bus.rom_q), 32'hBEEF);
      check("pf demand busy", 32'(bus.rom_busy), 0);
      bus.rom_ce_n = 1'b1;
      step();
      check("pf auto sd_req", 32'(bus.sd_req), 1);
      check("pf auto sd_addr", 32'(bus.sd_addr), 32'h004001);
      ack(16'h0102);
      check("pf done sd_req", 32'(bus.sd_req), 0);
      go(24'h008002, 1'b1);
      check("pf hit rom_q", 32'(bus.rom_q), 32'h0102);
      check("pf hit busy", 32'(bus.rom_busy), 0);
      step();
      check("pf promoted rom_q", 32'(bus.rom_q), 32'h0102);
      step();
      check("pf next sd_req", 32'(bus.sd_req), 1);
      check("pf next sd_addr", 32'(bus.sd_addr), 32'h004002);
      bus.rom_ce_n = 1'b1;
      ack(16'h0203);
      go(24'hFFFFFE, 1'b1);
      check("pf top miss busy", 32'(bus.rom_busy), 1);
      step();
      check("pf top sd_addr", 32'(bus.sd_addr), 32'h7FFFFF);
      ack(16'hCAFE);
      check("pf top rom_q", 32'(bus.rom_q), 32'hCAFE);
      step();
      check("pf wrap sd_req", 32'(bus.sd_req), 1);
      check("pf wrap sd_addr", 32'(bus.sd_addr), 32'h000000);
      go(24'h000000, 1'b1);
      check("pf inflight busy", 32'(bus.rom_busy), 1);
      ack(16'h4242);
      check("pf inflight rom_q", 32'(bus.rom_q), 32'h4242);
      check("pf inflight busy done", 32'(bus.rom_busy), 0);
      step();
      check("pf after inflight sd_addr", 32'(bus.sd_addr), 32'h000001);
      check("pf after inflight sd_req", 32'(bus.sd_req), 1);
      ack(16'h0001);
`else
      for (int i = 0; i < 8; i++) begin
         access($sformatf("vec%0d", i), tbl[i].addr, tbl[i].word, tbl[i].miss, tbl[i].fill,
                i % 3, tbl[i].exp_q);
      end

      // Address moves while a request is outstanding.
      do_reset();
      go(24'h008000, 1'b1);
      step();
      check("chg sd_addr first", 32'(bus.sd_addr), 32'h004000);
      bus.rom_addr = 24'h00A000;
      step();
      check("chg sd_addr held", 32'(bus.sd_addr), 32'h004000);
      check("chg busy", 32'(bus.rom_busy), 1);
      ack(16'h1111);
      check("chg busy after fill1", 32'(bus.rom_busy), 1);
      check("chg sd_req gap", 32'(bus.sd_req), 0);
      step();
      check("chg second sd_req", 32'(bus.sd_req), 1);
      check("chg second sd_addr", 32'(bus.sd_addr), 32'h005000);
      check("chg busy second", 32'(bus.rom_busy), 1);
      ack(16'h2222);
      check("chg rom_q", 32'(bus.rom_q), 32'h2222);
      check("chg busy done", 32'(bus.rom_busy), 0);
      step();

      // Reset during an outstanding request, then a stale ack.
      go(24'h00C000, 1'b1);
      step();
      check("rst pre sd_req", 32'(bus.sd_req), 1);
      bus.rom_ce_n = 1'b1;
      reset = 1'b1;
      #1;
      check("rst sd_req", 32'(bus.sd_req), 0);
      check("rst sd_addr", 32'(bus.sd_addr), 0);
      check("rst rom_q", 32'(bus.rom_q), 0);
      check("rst busy", 32'(bus.rom_busy), 0);
      step();
      reset = 1'b0;
      step();
      ack(16'h5555);
      check("stale ack sd_req", 32'(bus.sd_req), 0);
      check("stale ack rom_q", 32'(bus.rom_q), 0);
      step();
      check("stale ack no req", 32'(bus.sd_req), 0);
      access("post-rst reread", 24'h008000, 1'b1, 1'b1, 16'h7777, 1, 16'h7777);
      go(24'h008000, 1'b1);
      ack(16'hDEAD);
      check("idle ack rom_q", 32'(bus.rom_q), 32'h7777);
      check("idle ack sd_req", 32'(bus.sd_req), 0);

      // Random reads against a one-entry cache model.
      do_reset();
      mv = 1'b0;
      mt = '0;
      md = '0;
      for (int i = 0; i < 150; i++) begin
         w    = 23'h004000 + 23'($urandom_range(0, 4));
         a    = {w, 1'($urandom_range(0, 1))};
         wd   = 1'($urandom_range(0, 1));
         miss = !(mv && (mt == w));
         if (miss) begin
            mv = 1'b1;
            mt = w;
            md = mem(w);
         end
         last_q = fmt(md, a[0], wd);
         access($sformatf("rnd%0d", i), a, wd, miss, mem(w), int'($urandom_range(0, 3)), last_q);
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) bus.rom_ce_n = 1'b1;
            else bus.rom_oe_n = 1'b1;
            bus.rom_addr = 24'($urandom);
            bus.rom_word = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) step();
            check($sformatf("rnd%0d hold rom_q", i), 32'(bus.rom_q), 32'(last_q));
            check($sformatf("rnd%0d idle busy", i), 32'(bus.rom_busy), 0);
         end
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
